seg7_scan_32: RTL and testbench
===============================

Name: seg7_scan_32

Overview:
- Eight-digit, time-multiplexed seven-segment scan driver for the Nexys board display.
- Consumes the 32-bit word chosen by the display-select stage and drives CA..CG and AN[7:0].
- Latches the word once per frame to prevent tearing, inserts anti-ghosting guard cycles, and can optionally blank leading zeros and individual digits.
- Segment and anode outputs are active-low.

Parameters:
- SCAN_DIV, 100000: clocks per digit slot. Must be ≥ 2. At 100 MHz this gives 1 kHz per digit and 125 Hz per frame.
- GUARD, 16: clocks at the start of each slot with all anodes off. Must satisfy 0 ≤ GUARD < SCAN_DIV.
- LZ_BLANK, 0: 1 = blank digits above the most significant non-zero nibble. Digit 0 is always shown.

Ports:
- clk_i  in  1  system clock
- rst_i  in  1  asynchronous, active-high reset
- data_i  in  32  value to display; nibble k goes to digit k (digit 0 is rightmost)
- blank_i  in  8  per-digit blank mask; 1 = digit k dark
- CA, CB, CC, CD, CE, CF, CG  out  1 each  segments a..g, active-low
- AN  out  8  anodes, active-low; AN[k] selects digit k
- frame_o  out  1  one-cycle pulse when the shadow registers reload

Behaviour:
- Reset (asynchronous, takes effect immediately):
  - AN = 8'hFF, CA..CG = 1, frame_o = 0.
  - Prescaler cnt = 0, digit index idx = 0, guard counter g = 0.
  - Shadow data = 0, shadow blank = 0.
- Prescaler:
  - cnt increments every clock.
  - tick is asserted when cnt == SCAN_DIV-1; cnt then returns to 0.
- Digit index:
  - On tick, idx <= idx+1 mod 8 (7 wraps to 0).
  - On tick, g <= GUARD.
  - Otherwise g decrements while non-zero.
- Frame latch:
  - On a tick with idx == 7, shadow data <= data_i and shadow blank <= blank_i.
  - frame_o = 1 in the cycle after that tick, 0 otherwise.
  - Between latches, data_i and blank_i are ignored.
  - After reset the display shows shadow = 0 until the first wrap.
- Leading-zero suppression (when LZ_BLANK = 1):
  - Let m be the highest index with a non-zero shadow nibble, or m = 0 if all nibbles are zero.
  - Digits k > m are treated as blanked.
- Output registers (all outputs are registered; each reflects the cycle-N state at edge N+1):
  - If g != 0, or digit idx is blanked: AN = 8'hFF and segments = all 1.
  - Otherwise: AN = ~(8'b1 << idx), and segments = hex decode of shadow nibble idx.
- Hex decode (segments lit, everything else 1):
  - 0: a b c d e f
  - 1: b c
  - 2: a b d e g
  - 3: a b c d g
  - 4: b c f g
  - 5: a c d f g
  - 6: a c d e f g
  - 7: a b c
  - 8: all seven
  - 9: a b c d f g
  - A: a b c e f g
  - b: c d e f g
  - C: a d e f
  - d: b c d e g
  - E: a d e f g
  - F: a e f g
- Invariants:
  - At most one AN bit is low at any time.
  - No AN bit is low during the GUARD cycles after any digit change.
  - With GUARD = 0, the anode switches exactly one cycle after tick.
- Reset asserted mid-slot: outputs go to their reset values immediately, and scanning restarts at digit 0 with cnt = 0.

Test Plan (SCAN_DIV = 4, GUARD = 1 unless noted):
- Reset release with data_i = 32'h12345678: AN = FE showing "0" (CA..CG = 0000001) until the first wrap. frame_o pulses 1 cycle after the 8th tick. Then digit 0 shows "8" (all segments 0) and digit 7 shows "1" (CB = CC = 0, others 1).
- Guard check: after each tick, AN = FF for exactly 1 cycle, then one-hot-low for 3 cycles. The AN sequence is FE, FD, FB, …, 7F, then wraps to FE.
- Tear-free latch: change data_i from 32'hAAAAAAAA to 32'h55555555 while idx = 3. Digits 4..7 still show "A" until frame_o, then all digits show "5".
- blank_i = 8'b0000_0100: AN never drives bit 2 low; the slot for digit 2 has AN = FF and segments all 1.
- LZ_BLANK = 1, data_i = 32'h0000_00F0: only digits 0 ("0") and 1 ("F") light. With data_i = 0, only digit 0 lights, showing "0".
- Assert rst_i for 1 cycle while idx = 5: AN = FF and segments all 1 in that cycle, then scanning restarts at AN = FE.

Source files
------------

// File: rtl/seg7_scan_32.sv
// Eight-digit time-multiplexed seven-segment scan driver.
// Segments and anodes are active-low. The display word and blank mask are
// latched once per frame. Each digit slot starts with GUARD dark cycles, and
// leading zeros can optionally be suppressed.
module seg7_scan_32 #(
  parameter int unsigned SCAN_DIV = 100000,
  parameter int unsigned GUARD    = 16,
  parameter bit          LZ_BLANK = 1'b0
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] data_i,
  input  logic [7:0]  blank_i,
  output logic        CA,
  output logic        CB,
  output logic        CC,
  output logic        CD,
  output logic        CE,
  output logic        CF,
  output logic        CG,
  output logic [7:0]  AN,
  output logic        frame_o
);

  localparam int unsigned    CW       = $clog2(SCAN_DIV);
  localparam logic [CW-1:0]  CNT_LAST = CW'(SCAN_DIV - 1);
  localparam logic [CW-1:0]  GUARD_LD = CW'(GUARD);

  logic [CW-1:0] cnt;
  logic [CW-1:0] g;
  logic [2:0]    idx;
  logic          tick;

  logic [31:0]   shadow_data;
  logic [7:0]    shadow_blank;

  logic [2:0]    msd;
  logic [7:0]    lz_mask;
  logic [7:0]    dark_mask;
  logic          dark;
  logic [3:0]    nibble;
  logic [6:0]    seg_q;

  // Segment pattern for one hex nibble, bit order {a,b,c,d,e,f,g}, 0 = lit.
  function automatic logic [6:0] hex_seg(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'h0:    s = 7'b0000001;
      4'h1:    s = 7'b1001111;
      4'h2:    s = 7'b0010010;
      4'h3:    s = 7'b0000110;
      4'h4:    s = 7'b1001100;
      4'h5:    s = 7'b0100100;
      4'h6:    s = 7'b0100000;
      4'h7:    s = 7'b0001111;
      4'h8:    s = 7'b0000000;
      4'h9:    s = 7'b0000100;
      4'hA:    s = 7'b0001000;
      4'hB:    s = 7'b1100000;
      4'hC:    s = 7'b0110001;
      4'hD:    s = 7'b1000010;
      4'hE:    s = 7'b0110000;
      default: s = 7'b0111000;
    endcase
    return s;
  endfunction

  assign tick = (cnt == CNT_LAST);

  // Prescaler: one tick per digit slot.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt <= '0;
    end else if (tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  // Digit index advance and guard countdown at the start of each slot.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      idx <= '0;
      g   <= '0;
    end else if (tick) begin
      idx <= idx + 3'd1;
      g   <= GUARD_LD;
    end else if (g != '0) begin
      g <= g - 1'b1;
    end
  end

  // Frame latch: capture the word and mask as the scan wraps past digit 7.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      shadow_data  <= '0;
      shadow_blank <= '0;
      frame_o      <= 1'b0;
    end else begin
      frame_o <= tick && (idx == 3'd7);
      if (tick && (idx == 3'd7)) begin
        shadow_data  <= data_i;
        shadow_blank <= blank_i;
      end
    end
  end

  // Leading-zero mask: digits above the most significant non-zero nibble.
  always_comb begin
    msd     = '0;
    lz_mask = '0;
    for (int unsigned k = 1; k < 8; k++) begin
      if (shadow_data[4*k +: 4] != 4'h0) begin
        msd = 3'(k);
      end
    end
    if (LZ_BLANK) begin
      for (int unsigned k = 0; k < 8; k++) begin
        lz_mask[k] = (3'(k) > msd);
      end
    end
  end

  // Current digit is dark during the guard window or when masked.
  always_comb begin
    dark_mask = shadow_blank | lz_mask;
    dark      = (g != '0) || dark_mask[idx];
    nibble    = shadow_data[{idx, 2'b00} +: 4];
  end

  // Registered anode and segment drive.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      AN    <= '1;
      seg_q <= '1;
    end else if (dark) begin
      AN    <= '1;
      seg_q <= '1;
    end else begin
      AN    <= ~(8'b1 << idx);
      seg_q <= hex_seg(nibble);
    end
  end

  assign {CA, CB, CC, CD, CE, CF, CG} = seg_q;

endmodule

// File: tb/tb_seg7_scan_32.sv
module tb_seg7_scan_32;

  localparam logic [6:0] S0  = 7'b0000001;
  localparam logic [6:0] S1  = 7'b1001111;
  localparam logic [6:0] S5  = 7'b0100100;
  localparam logic [6:0] S7  = 7'b0001111;
  localparam logic [6:0] S8  = 7'b0000000;
  localparam logic [6:0] SA  = 7'b0001000;
  localparam logic [6:0] SF  = 7'b0111000;
  localparam logic [6:0] OFF = 7'b1111111;

  localparam int K_CHK = 0;
  localparam int K_DRV = 1;
  localparam int K_RST = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] data = '0;
  logic [7:0]  blank = '0;

  logic ca, cb, cc, cd, ce, cf, cg;
  logic [7:0] an;
  logic       frame;
  logic za, zb, zc, zd, ze, zf, zg;
  logic [7:0] an_lz;
  logic       frame_lz;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int at_neg = -1;

  typedef struct {
    int          j;
    int          kind;
    bit          sel;
    logic [31:0] data;
    logic [7:0]  blank;
    logic [7:0]  an;
    logic [6:0]  seg;
    logic        frame;
  } vec_t;

  vec_t vecs[$];

  always #5 clk = ~clk;

  seg7_scan_32 #(.SCAN_DIV(4), .GUARD(1), .LZ_BLANK(1'b0)) dut (
    .clk_i(clk), .rst_i(rst), .data_i(data), .blank_i(blank),
    .CA(ca), .CB(cb), .CC(cc), .CD(cd), .CE(ce), .CF(cf), .CG(cg),
    .AN(an), .frame_o(frame)
  );

  seg7_scan_32 #(.SCAN_DIV(4), .GUARD(1), .LZ_BLANK(1'b1)) dut_lz (
    .clk_i(clk), .rst_i(rst), .data_i(data), .blank_i(blank),
    .CA(za), .CB(zb), .CC(zc), .CD(zd), .CE(ze), .CF(zf), .CG(zg),
    .AN(an_lz), .frame_o(frame_lz)
  );

  function automatic void ck(int j, bit sel, logic [7:0] a, logic [6:0] s, logic f);
    vecs.push_back('{j, K_CHK, sel, 32'h0, 8'h0, a, s, f});
  endfunction

  function automatic void dv(int j, logic [31:0] d, logic [7:0] b, bit sel,
                             logic [7:0] a, logic [6:0] s, logic f);
    vecs.push_back('{j, K_DRV, sel, d, b, a, s, f});
  endfunction

  function automatic void rs(int j, bit sel, logic [31:0] d, logic [7:0] b);
    vecs.push_back('{j, K_RST, sel, d, b, 8'hFF, OFF, 1'b0});
  endfunction

  task automatic goto(input int j);
    while (cyc < j) begin
      @(posedge clk);
      cyc++;
    end
    if (at_neg != cyc) begin
      @(negedge clk);
      at_neg = cyc;
    end
  endtask

  task automatic compare(input string name, input int n, input bit sel,
                         input logic [7:0] a, input logic [6:0] s, input logic f);
    logic [7:0] ga;
    logic [6:0] gs;
    logic       gf;
    ga = sel ? an_lz : an;
    gs = sel ? {za, zb, zc, zd, ze, zf, zg} : {ca, cb, cc, cd, ce, cf, cg};
    gf = sel ? frame_lz : frame;
    checks++;
    if (ga !== a || gs !== s || gf !== f) begin
      errors++;
      $display("FAIL %s%0d cyc=%0d dut=%0d AN got %h want %h seg got %b want %b frame got %b want %b",
               name, n, cyc, sel, ga, a, gs, s, gf, f);
    end
  endtask

  task automatic do_reset(input logic [31:0] d, input logic [7:0] b);
    rst   = 1'b1;
    data  = d;
    blank = b;
    #1;
  endtask

  task automatic release_reset();
    @(negedge clk);
    rst    = 1'b0;
    cyc    = 0;
    at_neg = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    // Scenario A: power-up display of zeros, first latch, then 12345678.
    rs(0, 0, 32'h12345678, 8'h00);
    ck(1, 0, 8'hFE, S0, 0);
    ck(4, 0, 8'hFE, S0, 0);
    ck(5, 0, 8'hFF, OFF, 0);
    ck(6, 0, 8'hFD, S0, 0);
    ck(30, 0, 8'h7F, S0, 0);
    ck(31, 0, 8'h7F, S0, 0);
    ck(32, 0, 8'h7F, S0, 1);
    ck(33, 0, 8'hFF, OFF, 0);
    ck(34, 0, 8'hFE, S8, 0);
    ck(38, 0, 8'hFD, S7, 0);
    ck(46, 0, 8'hF7, S5, 0);
    ck(62, 0, 8'h7F, S1, 0);
    ck(64, 0, 8'h7F, S1, 1);
    // Scenario B: input change mid-frame must not tear the display.
    rs(0, 0, 32'hAAAAAAAA, 8'h00);
    ck(34, 0, 8'hFE, SA, 0);
    ck(44, 0, 8'hFB, SA, 0);
    dv(45, 32'h55555555, 8'h00, 0, 8'hFF, OFF, 0);
    ck(48, 0, 8'hF7, SA, 0);
    ck(50, 0, 8'hEF, SA, 0);
    ck(62, 0, 8'h7F, SA, 0);
    ck(64, 0, 8'h7F, SA, 1);
    ck(65, 0, 8'hFF, OFF, 0);
    ck(66, 0, 8'hFE, S5, 0);
    ck(94, 0, 8'h7F, S5, 0);
    // Scenario C: digit 2 blanked once the mask is latched.
    rs(0, 0, 32'h12345678, 8'h04);
    ck(10, 0, 8'hFB, S0, 0);
    ck(38, 0, 8'hFD, S7, 0);
    ck(41, 0, 8'hFF, OFF, 0);
    ck(42, 0, 8'hFF, OFF, 0);
    ck(44, 0, 8'hFF, OFF, 0);
    ck(46, 0, 8'hF7, S5, 0);
    // Scenario D: leading-zero suppression instance.
    rs(0, 1, 32'h000000F0, 8'h00);
    ck(2, 1, 8'hFE, S0, 0);
    ck(6, 1, 8'hFF, OFF, 0);
    ck(10, 1, 8'hFF, OFF, 0);
    ck(34, 1, 8'hFE, S0, 0);
    ck(38, 1, 8'hFD, SF, 0);
    dv(40, 32'h00000000, 8'h00, 1, 8'hFD, SF, 0);
    ck(42, 1, 8'hFF, OFF, 0);
    ck(62, 1, 8'hFF, OFF, 0);
    ck(66, 1, 8'hFE, S0, 0);
    ck(70, 1, 8'hFF, OFF, 0);
    // Scenario E: reset asserted while digit 5 is on.
    rs(0, 0, 32'h12345678, 8'h00);
    ck(22, 0, 8'hDF, S0, 0);
    rs(22, 0, 32'h12345678, 8'h00);
    ck(1, 0, 8'hFE, S0, 0);
    ck(4, 0, 8'hFE, S0, 0);
    ck(5, 0, 8'hFF, OFF, 0);
    ck(6, 0, 8'hFD, S0, 0);

    foreach (vecs[i]) begin
      goto(vecs[i].j);
      if (vecs[i].kind == K_RST) begin
        do_reset(vecs[i].data, vecs[i].blank);
        compare("rst", i, vecs[i].sel, vecs[i].an, vecs[i].seg, vecs[i].frame);
        release_reset();
      end else begin
        if (vecs[i].kind == K_DRV) begin
          data  = vecs[i].data;
          blank = vecs[i].blank;
        end
        compare("vec", i, vecs[i].sel, vecs[i].an, vecs[i].seg, vecs[i].frame);
      end
    end

    // Guard walk: every cycle of the first frame and a half, anode pattern only.
    @(negedge clk);
    do_reset(32'h12345678, 8'h00);
    release_reset();
    for (int j = 1; j <= 72; j++) begin
      logic [7:0] exp_an;
      int k;
      int p;
      goto(j);
      k = (j - 1) / 4;
      p = (j - 1) % 4;
      if (j <= 4)      exp_an = 8'hFE;
      else if (p == 0) exp_an = 8'hFF;
      else             exp_an = ~(8'b1 << (k % 8));
      checks++;
      if (an !== exp_an) begin
        errors++;
        $display("FAIL guard_an cyc=%0d AN got %h want %h", j, an, exp_an);
      end
      checks++;
      if (frame !== ((j == 32) || (j == 64))) begin
        errors++;
        $display("FAIL guard_frame cyc=%0d frame got %b want %b", j, frame,
                 (j == 32) || (j == 64));
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
